// File: rtl/seg_scan_driver_if.sv
// Write/commit port of the seven-segment scan driver: the menu logic drives raw
// segment patterns into the shadow buffer and requests publication.
interface seg_scan_driver_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_pending;

    // wr_en/commit are single-cycle strobes sampled on every clk edge; there
    // is no ready, a strobe is always accepted, and commit_pending reports
    // an accepted commit that has not yet reached the active buffer.
    modport master (output wr_en, output wr_addr, output wr_data, output commit,
                    input  commit_pending);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  commit,
                    output commit_pending);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a double-buffered pattern
// file, frame-aligned commits, per-digit blink and a global display enable.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 200000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [NUM_DIGITS-1:0] blink_mask_i,
    seg_scan_driver_if.slave      wr_if,
    output logic [NUM_DIGITS-1:0] seg_en_o,
    output logic [7:0]            tube1_o,
    output logic [7:0]            tube2_o,
    output logic                  frame_start_o
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0]         CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]         IDX_HALF  = IW'(NUM_DIGITS / 2);
    localparam logic [BW-1:0]         BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [4:0]            ADDR_LIM  = 5'(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE       = NUM_DIGITS'(1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic                  pend_q, pend_d;
    logic                  frame_q;
    logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
    logic [7:0]            tube1_q, tube1_d, tube2_q, tube2_d;
    logic [7:0]            shadow_q [NUM_DIGITS];
    logic [7:0]            active_q [NUM_DIGITS];
    logic                  tick, boundary, wr_ok;
    logic [7:0]            pat;

    assign tick     = (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == IDX_MAX);
    assign wr_ok    = wr_if.wr_en && ({1'b0, wr_if.wr_addr} < ADDR_LIM);

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        pend_d      = pend_q;
        if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        if (boundary) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        // A commit landing on the publishing boundary is kept for the next frame.
        if (boundary && pend_q) pend_d = wr_if.commit;
        else if (wr_if.commit)  pend_d = 1'b1;

        pat      = (phase_q && blink_mask_i[idx_q]) ? 8'h00 : active_q[idx_q];
        seg_en_d = '0;
        tube1_d  = 8'h00;
        tube2_d  = 8'h00;
        if (en_i) begin
            seg_en_d = ONE << idx_q;
            if (idx_q < IDX_HALF) tube1_d = pat;
            else                  tube2_d = pat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            frame_q     <= 1'b0;
            seg_en_q    <= '0;
            tube1_q     <= 8'h00;
            tube2_q     <= 8'h00;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= 8'h00;
                active_q[i] <= 8'h00;
            end
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            frame_q     <= boundary;
            seg_en_q    <= seg_en_d;
            tube1_q     <= tube1_d;
            tube2_q     <= tube2_d;
            // Publication copies the registered shadow, so a same-cycle write waits.
            if (boundary && pend_q) begin
                for (int i = 0; i < NUM_DIGITS; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_ok) shadow_q[wr_if.wr_addr[IW-1:0]] <= wr_if.wr_data;
        end
    end

    assign seg_en_o             = seg_en_q;
    assign tube1_o              = tube1_q;
    assign tube2_o              = tube2_q;
    assign frame_start_o        = frame_q;
    assign wr_if.commit_pending = pend_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed steps plus random traffic
// against a time-arithmetic reference of the scan, blink and commit rules.
module tb_seg_scan_driver;
  localparam int ND = 8;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = SD * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic [ND-1:0] seg_en;
  logic [7:0]    tube1, tube2;
  logic          frame_start;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .blink_mask_i(blink_mask),
    .wr_if(bus), .seg_en_o(seg_en), .tube1_o(tube1), .tube2_o(tube2),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: cycles since reset release, buffers, pending flag
  int         cyc;
  logic [7:0] shadow_m [ND];
  logic [7:0] active_m [ND];
  bit         pend_m;
  logic [ND-1:0] exp_seg;
  logic [7:0]    exp_t1, exp_t2;
  bit            exp_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    check("seg_en", 32'(seg_en), 32'(exp_seg));
    check("tube1", 32'(tube1), 32'(exp_t1));
    check("tube2", 32'(tube2), 32'(exp_t2));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("commit_pending", 32'(bus.commit_pending), 32'(pend_m));
  endtask

  task automatic model_clear();
    for (int i = 0; i < ND; i++) begin
      shadow_m[i] = 8'h00;
      active_m[i] = 8'h00;
    end
    pend_m  = 1'b0;
    cyc     = 0;
    exp_seg = '0;
    exp_t1  = 8'h00;
    exp_t2  = 8'h00;
    exp_fs  = 1'b0;
  endtask

  // One clock: the digit shown, boundaries and blink phase all follow from
  // the elapsed cycle count since reset.
  task automatic step();
    int idx;
    bit bnd, ph;
    logic [7:0] p;
    @(posedge clk);
    idx = (cyc / SD) % ND;
    bnd = (cyc % FRAME) == FRAME - 1;
    ph  = ((cyc / FRAME) / BF) % 2 == 1;
    p   = (ph && blink_mask[idx]) ? 8'h00 : active_m[idx];
    exp_seg = en ? ND'(1) << idx : '0;
    exp_t1  = (en && idx < ND / 2) ? p : 8'h00;
    exp_t2  = (en && idx >= ND / 2) ? p : 8'h00;
    exp_fs  = bnd;
    if (bnd && pend_m) begin
      for (int i = 0; i < ND; i++) active_m[i] = shadow_m[i];
      pend_m = bus.commit;
    end else if (bus.commit) begin
      pend_m = 1'b1;
    end
    if (bus.wr_en && bus.wr_addr < ND) shadow_m[bus.wr_addr] = bus.wr_data;
    cyc++;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 1'b0;
    model_clear();
    en = 1'b1;
    do_reset();

    // plain scan: one-hot walk, frame_start each 32 clk
    run(2 * FRAME);

    // two-digit write then mid-frame commit
    run(5);
    write(4'd0, 8'h8E);
    write(4'd7, 8'h06);
    do_commit();
    run(2 * FRAME);

    // shadow-only write stays hidden, then commit exactly on a boundary tick
    write(4'd3, 8'h3F);
    run(3 * FRAME);
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != FRAME - 1; i++) step();
    do_commit();
    run(2 * FRAME + 4);

    // out-of-range write leaves buffers untouched
    write(4'd9, 8'hFF);
    do_commit();
    run(2 * FRAME);

    // blink digit 0
    blink_mask = 8'h01;
    run(6 * FRAME);
    blink_mask = '0;

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 8'($urandom);
      bus.commit  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) en = ~en;
      if ($urandom_range(0, 63) == 0) blink_mask = ND'($urandom);
      step();
    end
    bus.wr_en = 1'b0; bus.commit = 1'b0;

    // enable drop mid-scan
    en = 1'b1;
    run(13);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(FRAME);

    // reset while a commit is pending
    write(4'd2, 8'h5B);
    do_commit();
    run(3);
    do_reset();
    run(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
